// File: rtl/bit_serial_adder_ctrl_if.sv
// Operand/result bundle for the bit-serial add/sub sequencer.
// master drives the request, slave returns status and results.
interface bit_serial_adder_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start_in;
    logic             sub_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
    logic             overflow_out;

    modport master (
        output start_in, sub_in, a_in, b_in,
        input  busy_out, done_out, sum_out, carry_out, overflow_out
    );

    modport slave (
        input  start_in, sub_in, a_in, b_in,
        output busy_out, done_out, sum_out, carry_out, overflow_out
    );
endinterface

// File: rtl/bit_serial_adder_ctrl.sv
// WIDTH-bit add/sub computed LSB-first through one shared full adder.
// Full adder is two half adders plus an OR on the carries.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module bit_serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    bit_serial_adder_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;

    logic             hs0;
    logic             hc0;
    logic             s_d;
    logic             hc1;
    logic             cnext_d;
    logic [WIDTH-1:0] sr_d;
    logic             last_d;

    half_adder u_ha0 (
        .a_i (sa_q[0]),
        .b_i (sb_q[0]),
        .s_o (hs0),
        .c_o (hc0)
    );

    half_adder u_ha1 (
        .a_i (hs0),
        .b_i (c_q),
        .s_o (s_d),
        .c_o (hc1)
    );

    assign cnext_d = hc0 | hc1;
    assign sr_d    = {s_d, sr_q[WIDTH-1:1]};
    assign last_d  = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start_in) begin
                        // Subtract as A + ~B + 1: carry-in supplies the +1
                        sa_q    <= bus.a_in;
                        sb_q    <= bus.sub_in ? ~bus.b_in : bus.b_in;
                        c_q     <= bus.sub_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    sr_q  <= sr_d;
                    c_q   <= cnext_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_d) begin
                        // c_q here is the carry into the MSB
                        sum_q   <= sr_d;
                        cout_q  <= cnext_d;
                        ovf_q   <= c_q ^ cnext_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy_out     = busy_q;
    assign bus.done_out     = done_q;
    assign bus.sum_out      = sum_q;
    assign bus.carry_out    = cout_q;
    assign bus.overflow_out = ovf_q;
endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Directed bench for the bit-serial add/sub sequencer.
// Covers a 32-bit and a 4-bit instance sharing clock and reset.
module tb_bit_serial_adder_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bit_serial_adder_ctrl_if #(.WIDTH(32)) u ();
    bit_serial_adder_ctrl_if #(.WIDTH(4))  u4 ();

    bit_serial_adder_ctrl #(.WIDTH(32)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (u.slave)
    );

    bit_serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (u4.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic op32(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic sub,
                        input logic [31:0] es, input logic ec,
                        input logic ev);
        int lat;
        int busyc;
        u.start_in = 1'b1;
        u.a_in     = a;
        u.b_in     = b;
        u.sub_in   = sub;
        @(posedge clk);
        #1;
        u.start_in = 1'b0;
        lat   = 0;
        busyc = 0;
        while (u.done_out !== 1'b1 && lat < 40) begin
            if (u.busy_out === 1'b1) busyc++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 32);
        chk({tag, "_busy_cycles"}, busyc, 32);
        chk({tag, "_busy_at_done"}, {31'd0, u.busy_out}, 0);
        chk({tag, "_sum"}, u.sum_out, es);
        chk({tag, "_carry"}, {31'd0, u.carry_out}, {31'd0, ec});
        chk({tag, "_ovf"}, {31'd0, u.overflow_out}, {31'd0, ev});
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, {31'd0, u.done_out}, 0);
    endtask

    initial begin
        int lat;
        int seen;
        u.start_in  = 1'b0;
        u.sub_in    = 1'b0;
        u.a_in      = '0;
        u.b_in      = '0;
        u4.start_in = 1'b0;
        u4.sub_in   = 1'b0;
        u4.a_in     = '0;
        u4.b_in     = '0;

        #12;
        chk("rst_busy", {31'd0, u.busy_out}, 0);
        chk("rst_done", {31'd0, u.done_out}, 0);
        chk("rst_sum", u.sum_out, 0);
        chk("rst_carry", {31'd0, u.carry_out}, 0);
        chk("rst_ovf", {31'd0, u.overflow_out}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        op32("add_ffff_1", 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
        op32("add_7fff_1", 32'h7FFF_FFFF, 32'h1, 1'b0,
             32'h8000_0000, 1'b0, 1'b1);
        op32("sub_5_3", 32'd5, 32'd3, 1'b1, 32'h2, 1'b1, 1'b0);
        op32("sub_3_5", 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        op32("sub_8000_1", 32'h8000_0000, 32'h1, 1'b1,
             32'h7FFF_FFFF, 1'b1, 1'b1);

        // Inputs disturbed while running must not matter
        u.start_in = 1'b1;
        u.a_in     = 32'h1234_5678;
        u.b_in     = 32'h1111_1111;
        u.sub_in   = 1'b0;
        @(posedge clk);
        #1;
        u.start_in = 1'b0;
        for (int i = 1; i < 32; i++) begin
            if (i == 3) begin
                u.start_in = 1'b1;
                u.a_in     = 32'hFFFF_FFFF;
                u.b_in     = 32'h0000_0001;
                u.sub_in   = 1'b1;
            end
            if (i == 8) u.start_in = 1'b0;
            if (i == 20) begin
                chk("hold_sum", u.sum_out, 32'h7FFF_FFFF);
                chk("hold_carry", {31'd0, u.carry_out}, 1);
                chk("hold_busy", {31'd0, u.busy_out}, 1);
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk("dist_done", {31'd0, u.done_out}, 1);
        chk("dist_sum", u.sum_out, 32'h2345_6789);
        chk("dist_carry", {31'd0, u.carry_out}, 0);
        chk("dist_ovf", {31'd0, u.overflow_out}, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (u.busy_out === 1'b1) seen++;
        end
        chk("dist_no_restart", seen, 0);

        // 4-bit instance
        u4.start_in = 1'b1;
        u4.a_in     = 4'h9;
        u4.b_in     = 4'h8;
        u4.sub_in   = 1'b0;
        @(posedge clk);
        #1;
        u4.start_in = 1'b0;
        lat = 0;
        while (u4.done_out !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("w4_latency", lat, 4);
        chk("w4_sum", {28'd0, u4.sum_out}, 32'h1);
        chk("w4_carry", {31'd0, u4.carry_out}, 1);
        chk("w4_ovf", {31'd0, u4.overflow_out}, 1);

        // Abort at cycle 10 of an operation
        @(posedge clk);
        #1;
        u.start_in = 1'b1;
        u.a_in     = 32'h0F0F_0F0F;
        u.b_in     = 32'h1010_1010;
        u.sub_in   = 1'b0;
        @(posedge clk);
        #1;
        u.start_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, u.busy_out}, 0);
        chk("abort_done", {31'd0, u.done_out}, 0);
        chk("abort_sum", u.sum_out, 0);
        chk("abort_carry", {31'd0, u.carry_out}, 0);
        chk("abort_ovf", {31'd0, u.overflow_out}, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (u.done_out === 1'b1) seen++;
        end
        chk("abort_no_done", seen, 0);

        op32("after_abort", 32'd100, 32'd23, 1'b0, 32'd123, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
